// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
// One-entry result buffer per FU, round-robin granted onto a registered CDB; 2 cycles input to broadcast.
// A buffer accepts only when empty or draining this cycle; flush empties all buffers and blocks acceptance.
module cdb_arbiter #(
  parameter int FU_COUNT = 8,
  parameter int DATA_W   = 8,
  parameter int TAG_W    = 4,
  parameter int ROB_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [FU_COUNT-1:0]       res_valid,
  output logic [FU_COUNT-1:0]       res_ready,
  input  logic [FU_COUNT*DATA_W-1:0] res_val,
  input  logic [FU_COUNT*TAG_W-1:0]  res_tag,
  input  logic [FU_COUNT*ROB_W-1:0]  res_robid,
  output logic                      cdbtransmit,
  output logic [DATA_W-1:0]         cdbval,
  output logic [TAG_W-1:0]          cdbid,
  output logic [ROB_W-1:0]          cdbrobid,
  output logic [FU_COUNT-1:0]       fus_busy
);

  localparam int PTR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  logic [FU_COUNT-1:0] buf_v;
  logic [DATA_W-1:0]   buf_val   [FU_COUNT];
  logic [TAG_W-1:0]    buf_tag   [FU_COUNT];
  logic [ROB_W-1:0]    buf_robid [FU_COUNT];

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_next;

  logic [FU_COUNT-1:0] grant;
  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W:0]      sum;
  logic [PTR_W-1:0]    cand;

  // Scan from rr_ptr upward with wrap; the first occupied buffer wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    if (!flush) begin
      for (int off = 0; off < FU_COUNT; off++) begin
        sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
        if (sum >= (PTR_W+1)'(FU_COUNT)) begin
          sum = sum - (PTR_W+1)'(FU_COUNT);
        end
        cand = sum[PTR_W-1:0];
        if (!grant_any && buf_v[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (grant_any) begin
      rr_next = (grant_idx == PTR_W'(FU_COUNT-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // A buffer being granted this cycle can take a new result with no bubble.
  assign res_ready = flush ? '0 : (~buf_v | grant);
  assign fus_busy  = buf_v;

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_v       <= '0;
      rr_ptr      <= '0;
      cdbtransmit <= 1'b0;
      cdbval      <= '0;
      cdbid       <= '0;
      cdbrobid    <= '0;
      for (int i = 0; i < FU_COUNT; i++) begin
        buf_val[i]   <= '0;
        buf_tag[i]   <= '0;
        buf_robid[i] <= '0;
      end
    end else begin
      cdbtransmit <= grant_any;
      rr_ptr      <= rr_next;
      if (grant_any) begin
        cdbval   <= buf_val[grant_idx];
        cdbid    <= buf_tag[grant_idx];
        cdbrobid <= buf_robid[grant_idx];
      end
      for (int i = 0; i < FU_COUNT; i++) begin
        if (flush) begin
          buf_v[i] <= 1'b0;
        end else if (res_valid[i] && res_ready[i]) begin
          buf_v[i]     <= 1'b1;
          buf_val[i]   <= res_val[i*DATA_W +: DATA_W];
          buf_tag[i]   <= res_tag[i*TAG_W +: TAG_W];
          buf_robid[i] <= res_robid[i*ROB_W +: ROB_W];
        end else if (grant[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits between the functional units and the common data bus that feeds the issuer's reservation stations (cdbval/cdbid/cdbtransmit).
- Each FU holds its completed result in a one-entry buffer. A round-robin arbiter grants one buffer per cycle onto the registered CDB outputs.
- Buffer occupancy is exported as fus_busy so the issuer stops dispatching to an FU whose result has not yet broadcast.

Parameters:
FU_COUNT, 8, number of functional units / requesters
DATA_W, 8, result value width
TAG_W, 4, physical register tag width (matches cdbid)
ROB_W, 8, ROB id width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
flush  input  1  pipeline flush; discards all pending results
res_valid  input  FU_COUNT  FU i presents a result
res_ready  output  FU_COUNT  buffer i can accept this cycle
res_val  input  FU_COUNT x DATA_W packed  result values
res_tag  input  FU_COUNT x TAG_W packed  destination phys reg tags
res_robid  input  FU_COUNT x ROB_W packed  ROB ids
cdbtransmit  output  1  CDB broadcast valid
cdbval  output  DATA_W  broadcast value
cdbid  output  TAG_W  broadcast tag
cdbrobid  output  ROB_W  broadcast ROB id
fus_busy  output  FU_COUNT  buffer i occupied (to issuer)

Behaviour:
- Reset (rst=0 at clock edge): all buffers invalid; rr_ptr=0; cdbtransmit=0; cdbval/cdbid/cdbrobid=0; fus_busy=0. Reset overrides flush and every handshake. A result presented during reset is lost.
- res_ready[i] = !flush && (!buf_v[i] || grant[i]). This is combinational from registered state and does not depend on res_valid.
- Accept: res_valid[i] && res_ready[i] at edge → buffer i loads val/tag/robid, buf_v[i]=1.
- Simultaneous grant and accept on the same FU: the old entry goes to the CDB and the new entry replaces it. buf_v stays 1 and there is no bubble.
- Arbitration is combinational over buf_v:
  - grant = first set bit at or after rr_ptr, wrapping modulo FU_COUNT.
  - At most one grant per cycle.
  - After a grant to k, rr_ptr = (k+1) mod FU_COUNT. rr_ptr is unchanged when nothing is granted.
- Output register:
  - Granted entry → cdbval/cdbid/cdbrobid, cdbtransmit=1 in the next cycle. The granted buffer clears unless it is refilled the same cycle.
  - No grant → cdbtransmit=0, data outputs hold their previous values.
- Latency: accept at edge N → earliest cdbtransmit=1 during cycle after edge N+1 (2 cycles, input to broadcast).
- fus_busy = buf_v, registered.
- Fairness: a valid buffer is granted within FU_COUNT cycles. Throughput is 1 broadcast per cycle while any buffer is valid.
- Flush (rst=1, flush=1 at edge): all buf_v=0, cdbtransmit=0 next cycle, no grant issued. res_ready=0 during the flush cycle, so no result is accepted. rr_ptr is retained.
- Flush mid-broadcast: a cdbtransmit already high in the flush cycle completes. Only the following cycle is suppressed.
- Tag width: tags are broadcast unchanged. Tag 0 is a legal tag and gets no special treatment.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles with res_valid=8'hFF → cdbtransmit=0, fus_busy=0, outputs 0. After release, res_ready=8'hFF.
- Single result: FU 3 presents val=8'hAA, tag=4'h1, robid=8'h05 for one cycle → fus_busy[3]=1 next cycle. On the following cycle cdbtransmit=1, cdbval=AA, cdbid=1, cdbrobid=05, then fus_busy[3]=0.
- Round-robin: FUs 0, 2, 5 each present one result in the same cycle with rr_ptr=0 → broadcasts in order 0, 2, 5 on consecutive cycles. Then FU 0 and FU 5 refill: order 0 then 5 (rr_ptr=6 wraps).
- Back-to-back same FU: FU 1 holds res_valid=1 with robid 10,11,12,13 → robids broadcast consecutively with no bubble; res_ready[1] stays 1.
- Backpressure: all 8 FUs full and re-presenting → 8 broadcasts in order 0..7. Each FU's res_ready is high only in its grant cycle; no entry is starved or duplicated.
- Flush: buffers 2, 4 valid, pulse flush while FU 6 presents → fus_busy=0 next cycle, cdbtransmit=0, FU 6 result not accepted. A new result from FU 4 after flush is broadcast normally.
